// File: rtl/mvu_fold_seq_if.sv
// mvu_fold_seq_if: control bundle between the fold sequencer and the MVU datapath
interface mvu_fold_seq_if #(
  parameter int IBW = 2,
  parameter int WAW = 4
);
  logic           in_v;
  logic           in_rdy;
  logic           ib_wr_en;
  logic [IBW-1:0] ib_addr;
  logic           src_sel;
  logic [WAW-1:0] wmem_addr;
  logic           issue;
  logic           acc_clr;
  logic           pe_en;
  logic           out_v;
  logic           out_rdy;
  modport master (
    input  in_v, out_rdy,
    output in_rdy, ib_wr_en, ib_addr, src_sel, wmem_addr, issue, acc_clr, pe_en, out_v
  );
  modport slave (
    output in_v, out_rdy,
    input  in_rdy, ib_wr_en, ib_addr, src_sel, wmem_addr, issue, acc_clr, pe_en, out_v
  );
endinterface

// File: rtl/mvu_fold_seq.sv
// mvu_fold_seq: SF x NF fold sequencer; fills the input buffer on neuron fold 0, replays it after
module mvu_fold_seq #(
  parameter int MatrixW = 16,
  parameter int MatrixH = 12,
  parameter int SIMD    = 4,
  parameter int PE      = 4,
  parameter int PE_LAT  = 2
) (
  input  logic           clk,
  input  logic           rst,
  mvu_fold_seq_if.master ctl_io
);
  localparam int SF  = MatrixW / SIMD;
  localparam int NF  = MatrixH / PE;
  localparam int IBW = SF > 1 ? $clog2(SF) : 1;
  localparam int NFW = NF > 1 ? $clog2(NF) : 1;
  localparam int WAW = SF * NF > 1 ? $clog2(SF * NF) : 1;
  typedef enum logic {FILL, REUSE} state_t;
  state_t            state_q, state_d;
  logic [IBW-1:0]    sf_q, sf_d;
  logic [NFW-1:0]    nf_q, nf_d;
  logic [PE_LAT-1:0] tag_q, tag_d;
  logic              stall, in_rdy, issue, sf_wrap, nf_wrap, last;
  always_comb begin
    stall   = tag_q[PE_LAT-1] && !ctl_io.out_rdy;
    in_rdy  = !rst && state_q == FILL && !stall;
    issue   = state_q == FILL ? ctl_io.in_v && in_rdy : !stall;
    sf_wrap = sf_q == IBW'(SF - 1);
    nf_wrap = nf_q == NFW'(NF - 1);
    last    = issue && sf_wrap;
    sf_d    = issue ? (sf_wrap ? '0 : sf_q + 1'b1) : sf_q;
    nf_d    = last ? (nf_wrap ? '0 : nf_q + 1'b1) : nf_q;
    state_d = last ? (nf_wrap ? FILL : REUSE) : state_q;
    // last tags ride alongside the datapath so out_v lines up with the accumulator result
    tag_d   = stall ? tag_q : (tag_q << 1) | PE_LAT'(last);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      sf_q    <= '0;
      nf_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= sf_d;
      nf_q    <= nf_d;
      tag_q   <= tag_d;
    end
  end
  assign ctl_io.in_rdy    = in_rdy;
  assign ctl_io.issue     = issue;
  assign ctl_io.ib_wr_en  = state_q == FILL && issue;
  assign ctl_io.ib_addr   = sf_q;
  assign ctl_io.src_sel   = state_q == REUSE;
  assign ctl_io.wmem_addr = WAW'(nf_q * SF + sf_q);
  assign ctl_io.acc_clr   = issue && sf_q == '0;
  assign ctl_io.pe_en     = !stall;
  assign ctl_io.out_v     = tag_q[PE_LAT-1];
endmodule

// File: tb/tb_mvu_fold_seq.sv
// tb_mvu_fold_seq: randomized check of the fold sequencer against a fold-position model
module tb_mvu_fold_seq;
  localparam int SF = 4, NF = 3, LAT = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mvu_fold_seq_if #(.IBW(2), .WAW(4)) if0 ();
  mvu_fold_seq_if #(.IBW(1), .WAW(1)) if1 ();
  mvu_fold_seq dut0 (.clk(clk), .rst(rst), .ctl_io(if0));
  mvu_fold_seq #(.MatrixW(4), .MatrixH(4), .SIMD(4), .PE(4), .PE_LAT(1)) dut1 (.clk(clk), .rst(rst), .ctl_io(if1));
  int checks = 0, errors = 0;
  int k = 0, en_edges = 0;
  int tq[$];
  logic e_rdy, e_wr, e_src, e_iss, e_clr, e_pe, e_ov;
  localparam logic [12:0] RST_VEC = 13'b0_0_00_0_0000_0_0_1_0;
  function automatic logic [12:0] dut_vec();
    return {if0.in_rdy, if0.ib_wr_en, if0.ib_addr, if0.src_sel, if0.wmem_addr,
            if0.issue, if0.acc_clr, if0.pe_en, if0.out_v};
  endfunction
  function automatic logic [12:0] exp_vec();
    return {e_rdy, e_wr, 2'(k % SF), e_src, 4'(k), e_iss, e_clr, e_pe, e_ov};
  endfunction
  // k is the beat position within the vector; a row group's result is due LAT enabled edges after its last beat
  task automatic model_eval();
    e_ov  = tq.size() > 0 && tq[0] == en_edges;
    e_pe  = !(e_ov && !if0.out_rdy);
    e_rdy = k < SF && e_pe;
    e_iss = k < SF ? if0.in_v && e_pe : e_pe;
    e_wr  = k < SF && e_iss;
    e_src = k >= SF;
    e_clr = e_iss && k % SF == 0;
  endtask
  task automatic model_adv();
    if (e_iss) begin
      if (k % SF == SF - 1) tq.push_back(en_edges + LAT);
      k = (k + 1) % (SF * NF);
    end
    if (e_pe) en_edges++;
    while (tq.size() > 0 && tq[0] < en_edges) void'(tq.pop_front());
  endtask
  task automatic drive(input logic v, input logic r);
    if0.in_v = v;
    if0.out_rdy = r;
    @(negedge clk);
    model_eval();
  endtask
  task automatic next();
    model_adv();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    if0.in_v = 0;
    if0.out_rdy = 1;
    if1.in_v = 0;
    if1.out_rdy = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    k = 0;
    tq.delete();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    if0.in_v = 1;
    if0.out_rdy = 1;
    rst = 1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset got %b exp %b", dut_vec(), RST_VEC);
    end
    do_reset();
  endtask
  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(1, 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stream cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      next();
    end
  endtask
  task automatic test_gaps();
    do_reset();
    for (int c = 0; c < 24; c++) begin
      drive(c < 8 ? logic'(c % 2 == 0) : logic'($urandom_range(0, 1)), 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gaps cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      next();
    end
  endtask
  task automatic test_stall();
    int held = 0;
    do_reset();
    for (int c = 0; c < 30 && held < 5; c++) begin
      drive(1, 0);
      if (e_ov) held++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      next();
    end
    checks++;
    if (held != 5) begin
      errors++;
      $display("FAIL stall_hold got %0d cycles exp 5", held);
    end
    for (int c = 0; c < 16; c++) begin
      drive(1, 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_release cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      next();
    end
  endtask
  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      drive(1, 1);
      if (if0.out_v) pulses++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      next();
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL b2b_pulses got %0d exp 6", pulses);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    repeat (6) begin
      drive(1, 1);
      next();
    end
    #1;
    rst = 1;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL mid_reset got %b exp %b", dut_vec(), RST_VEC);
    end
    if0.in_v = 0;
    @(negedge clk);
    rst = 0;
    k = 0;
    tq.delete();
    @(posedge clk);
    #1;
    drive(1, 1);
    checks++;
    if ({if0.wmem_addr, if0.acc_clr, if0.ib_wr_en, if0.issue} !== 7'b0000_1_1_1) begin
      errors++;
      $display("FAIL mid_reset_restart got %b exp 0000111",
               {if0.wmem_addr, if0.acc_clr, if0.ib_wr_en, if0.issue});
    end
    next();
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %b exp %b", c, dut_vec(), exp_vec());
      end
      next();
    end
  endtask
  task automatic test_sf1();
    logic prev = 0, v;
    logic [8:0] got, exp;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      v = c < 10 ? 1'b1 : logic'($urandom_range(0, 1));
      if1.in_v = v;
      if1.out_rdy = 1;
      @(negedge clk);
      got = {if1.in_rdy, if1.ib_wr_en, if1.ib_addr, if1.src_sel, if1.wmem_addr,
             if1.issue, if1.acc_clr, if1.pe_en, if1.out_v};
      exp = {1'b1, v, 1'b0, 1'b0, 1'b0, v, v, 1'b1, prev};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sf1 cyc %0d got %b exp %b", c, got, exp);
      end
      prev = v;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    if0.in_v = 0;
    if0.out_rdy = 1;
    if1.in_v = 0;
    if1.out_rdy = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_gaps();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_sf1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
